// File: rtl/arith_seq_pkg.sv
// Shared types for the sequential arithmetic controller.
// Opcode and FSM state encodings, plus iteration-counter sizing.
// Imported by the controller top and the division step.
package arith_seq_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    MOD = 3'd4,
    POW = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIV_ITER = 3'd1,
    DIV_FIX  = 3'd2,
    POW_ITER = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Counter width needed to count 0..w-1 (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/arith_seq_divstep.sv
// One restoring-division step: shift in next dividend bit, trial-subtract.
// Purely combinational, zero latency.
// No flow control; the controller iterates it once per cycle.
module arith_seq_divstep
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Partial remainder gains the dividend MSB held at the top of the quotient register.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - dvs_i;
    if (shifted >= {1'b0, dvs_i}) begin
      rem_o = diff;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/arith_seq_ctrl.sv
// Request/response controller sharing one arithmetic datapath (add/sub/mul/div/mod/pow).
// Latency: fast ops and early-outs 1 cycle, div/mod WIDTH+2, pow WIDTH+1.
// One request in flight; req_ready only in IDLE; response held until rsp_ready.
module arith_seq_ctrl
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [ID_W-1:0]  req_id,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [ID_W-1:0]  rsp_id
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q, mod_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [ID_W-1:0]  rsp_id_q;

  // Accept-time decode.
  state_t           state_d;
  logic [WIDTH-1:0] data_d, abs_a_d, abs_b_d;
  logic             err_d, sa_d, sb_d;

  // Iteration datapath.
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] pow_acc_d, pow_base_d;
  logic [WIDTH-1:0] q_fix_d, r_fix_d;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;

  arith_seq_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (b_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Decode an incoming request: single-cycle results, early-outs, or which loop to enter.
  always_comb begin
    sa_d    = req_signed & req_a[WIDTH-1];
    sb_d    = req_signed & req_b[WIDTH-1];
    abs_a_d = sa_d ? -req_a : req_a;
    abs_b_d = sb_d ? -req_b : req_b;
    state_d = RESP;
    data_d  = '0;
    err_d   = 1'b0;
    case (req_op)
      ADD: data_d = req_a + req_b;
      SUB: data_d = req_a - req_b;
      MUL: data_d = req_a * req_b;
      DIV, MOD: begin
        if (req_b == '0) begin
          err_d  = 1'b1;
          data_d = (req_op == DIV) ? '1 : req_a;
        end else begin
          state_d = DIV_ITER;
        end
      end
      POW: begin
        if (sb_d) begin
          // Negative exponent: only |a|==1 has a non-zero integer result.
          if (req_a == WIDTH'(1)) begin
            data_d = WIDTH'(1);
          end else if (req_a == '1) begin
            data_d = req_b[0] ? '1 : WIDTH'(1);
          end else if (req_a == '0) begin
            data_d = '1;
            err_d  = 1'b1;
          end else begin
            data_d = '0;
          end
        end else begin
          state_d = POW_ITER;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  // Square-and-multiply step, exponent consumed LSB-first from b_q; sign fix-up for division.
  always_comb begin
    pow_acc_d  = b_q[0] ? acc_q * a_q : acc_q;
    pow_base_d = a_q * a_q;
    q_fix_d    = qneg_q ? -quo_q : quo_q;
    r_fix_d    = rneg_q ? -rem_q : rem_q;
  end

  // Controller FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      mod_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q    <= state_d;
            rsp_data_q <= data_d;
            rsp_err_q  <= err_d;
            rsp_id_q   <= req_id;
            a_q        <= req_a;
            b_q        <= abs_b_d;
            quo_q      <= abs_a_d;
            rem_q      <= '0;
            acc_q      <= WIDTH'(1);
            cnt_q      <= '0;
            qneg_q     <= sa_d ^ sb_d;
            rneg_q     <= sa_d;
            mod_q      <= (req_op == MOD);
          end
        end
        DIV_ITER: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          rsp_data_q <= mod_q ? r_fix_d : q_fix_d;
          rsp_err_q  <= 1'b0;
          state_q    <= RESP;
        end
        POW_ITER: begin
          acc_q <= pow_acc_d;
          a_q   <= pow_base_d;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            rsp_data_q <= pow_acc_d;
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Scoreboard bench for arith_seq_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares data, err, id and response latency.
// Also covers reset state, response hold under backpressure and mid-divide reset.
module tb_arith_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic       req_signed = 1'b0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [3:0] req_id = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] rsp_id;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [3:0] id;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  arith_seq_ctrl #(.WIDTH(8), .ID_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_id     (req_id),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: record accept times, response rise times, and score each consumed response.
  initial begin
    int   ncyc;
    int   rise_n;
    int   t;
    logic prev_v;
    exp_t e;
    ncyc   = 0;
    rise_n = 0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) begin
        acc_q.delete();
        prev_v = 1'b0;
      end else begin
        if (req_valid && req_ready) acc_q.push_back(ncyc);
        if (rsp_valid && !prev_v) rise_n = ncyc;
        prev_v = rsp_valid;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data 0x%0h id %0d, expected no response", rsp_data, rsp_id);
          end else begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            chk($sformatf("rsp_data id%0d", e.id), 32'(rsp_data), 32'(e.data));
            chk($sformatf("rsp_err id%0d", e.id), 32'(rsp_err), 32'(e.err));
            chk($sformatf("rsp_id id%0d", e.id), 32'(rsp_id), 32'(e.id));
            chk($sformatf("latency id%0d", e.id), 32'(rise_n - t), 32'(e.lat));
          end
        end
      end
    end
  end

  // Issue one request; optionally queue its expected response first.
  task automatic send(input logic [2:0] op, input logic sg, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] id, input logic want, input logic [7:0] ed, input logic ee,
                      input int lat);
    exp_t e;
    logic acc;
    if (want) begin
      e.data = ed;
      e.err  = ee;
      e.id   = id;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_op     = op;
    req_signed = sg;
    req_a      = a;
    req_b      = b;
    req_id     = id;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout id%0d: got req_ready low for 64 cycles, expected acceptance", id);
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADD 200+100 with the response held back for 3 cycles
    rsp_ready = 1'b0;
    send(3'd0, 1'b0, 8'd200, 8'd100, 4'd3, 1'b1, 8'h2C, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold rsp_data", 32'(rsp_data), 32'h2C);
      chk("hold rsp_err", 32'(rsp_err), 32'd0);
      chk("hold rsp_id", 32'(rsp_id), 32'd3);
      chk("hold req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;

    // op, signed, a, b, id, expect, data, err, latency
    send(3'd1, 1'b0, 8'd5,    8'd10,   4'd1,  1'b1, 8'hFB, 1'b0, 1);   // 5-10
    send(3'd2, 1'b1, 8'hFD,   8'd5,    4'd2,  1'b1, 8'hF1, 1'b0, 1);   // -3*5
    send(3'd3, 1'b1, 8'hF9,   8'd2,    4'd4,  1'b1, 8'hFD, 1'b0, 10);  // -7/2
    send(3'd4, 1'b1, 8'hF9,   8'd2,    4'd5,  1'b1, 8'hFF, 1'b0, 10);  // -7%2
    send(3'd3, 1'b0, 8'd200,  8'd7,    4'd6,  1'b1, 8'd28, 1'b0, 10);  // 200/7
    send(3'd4, 1'b0, 8'd200,  8'd7,    4'd7,  1'b1, 8'd4,  1'b0, 10);  // 200%7
    send(3'd3, 1'b1, 8'h80,   8'hFF,   4'd8,  1'b1, 8'h80, 1'b0, 10);  // -128/-1
    send(3'd4, 1'b1, 8'h80,   8'hFF,   4'd9,  1'b1, 8'h00, 1'b0, 10);  // -128%-1
    send(3'd3, 1'b0, 8'd5,    8'd0,    4'd10, 1'b1, 8'hFF, 1'b1, 1);   // 5/0
    send(3'd4, 1'b0, 8'd5,    8'd0,    4'd11, 1'b1, 8'd5,  1'b1, 1);   // 5%0
    send(3'd5, 1'b0, 8'd3,    8'd5,    4'd12, 1'b1, 8'hF3, 1'b0, 9);   // 3**5
    send(3'd5, 1'b0, 8'd2,    8'd8,    4'd13, 1'b1, 8'h00, 1'b0, 9);   // 2**8
    send(3'd5, 1'b1, 8'hFE,   8'd3,    4'd14, 1'b1, 8'hF8, 1'b0, 9);   // (-2)**3
    send(3'd5, 1'b0, 8'd0,    8'd0,    4'd15, 1'b1, 8'h01, 1'b0, 9);   // 0**0
    send(3'd5, 1'b1, 8'hFF,   8'hFD,   4'd1,  1'b1, 8'hFF, 1'b0, 1);   // (-1)**-3
    send(3'd5, 1'b1, 8'hFF,   8'hFE,   4'd2,  1'b1, 8'h01, 1'b0, 1);   // (-1)**-2
    send(3'd5, 1'b1, 8'd2,    8'hFF,   4'd3,  1'b1, 8'h00, 1'b0, 1);   // 2**-1
    send(3'd5, 1'b1, 8'd0,    8'hFE,   4'd4,  1'b1, 8'hFF, 1'b1, 1);   // 0**-2
    send(3'd7, 1'b0, 8'd9,    8'd9,    4'd5,  1'b1, 8'h00, 1'b1, 1);   // illegal 7
    send(3'd6, 1'b1, 8'd9,    8'd9,    4'd6,  1'b1, 8'h00, 1'b1, 1);   // illegal 6

    // Reset in the middle of a divide: no response may ever appear for it
    send(3'd3, 1'b0, 8'd100,  8'd3,    4'd9,  1'b0, 8'h00, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    repeat (15) @(posedge clk);

    // Controller still usable after the abort
    send(3'd0, 1'b1, 8'hFF,   8'hFF,   4'd7,  1'b1, 8'hFE, 1'b0, 1);   // -1+-1

    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
